darkram_responder: RTL
======================

Name: darkram_responder

Overview:
- Memory-side responder for the darkriscv core bus: serves instruction fetches (IADDR/IDATA) and data accesses (DADDR/DATAO/DATAI/DLEN/DRD/DWR/DAS).
- Stretches each data access by a programmable number of wait states via HLT.
- Used as the DUT-side memory model in the darksimv bench and as the simple-SoC RAM.
- Single unified word-addressed array, shared by both ports.

Parameters:
- MEM_AW, 12, word-address width; array depth 2**MEM_AW words of 32 bits.
- WAIT_STATES, 0, extra HLT cycles per data access, range 0..15.
- INIT_FILE, "darksocv.mem", hex image loaded with $readmemh at time 0; empty string skips the load.

Ports:
- CLK  in  1  core clock.
- RES  in  1  reset; asynchronous, active-high.
- IADDR  in  32  instruction fetch byte address.
- IDATA  out  32  fetched instruction, registered.
- DAS  in  1  data access strobe.
- DRD  in  1  data read request.
- DWR  in  1  data write request.
- DADDR  in  32  data byte address.
- DATAO  in  32  write data from core, lane-replicated.
- DLEN  in  3  access size, one-hot: 001 byte, 010 half, 100 word.
- DATAI  out  32  read data: full aligned word, registered; the core performs lane extraction.
- HLT  out  1  stall request to core.
- ERR  out  1  sticky misaligned or illegal-DLEN flag.

Behaviour:
- Reset values (RES high, asynchronous): state=IDLE, wait counter=0, IDATA=32'h00000013 (NOP), DATAI=0, ERR=0, HLT=0.
  - HLT is forced 0 while RES is high.
  - Array contents are not reset.
- Data FSM states: IDLE, WAIT, DONE. A request is DAS & (DRD|DWR).
  - IDLE with a request: latch address, data, DLEN and direction. Load counter=WAIT_STATES. Go to WAIT if WAIT_STATES>0, else DONE. HLT=1 this cycle.
  - WAIT: HLT=1 and the counter decrements. When the counter reaches 1, the next state is DONE.
  - DONE: HLT=0. DATAI holds the read word, written at the DONE entry edge. A write commits at the edge ending DONE. Next state is IDLE.
  - A request seen in IDLE on the cycle after DONE is a new access.
  - Net stall is WAIT_STATES+1 cycles per access. Access-to-data latency is WAIT_STATES+1 edges.
- Request deasserted in WAIT: the access is aborted and the FSM returns to IDLE; no write is performed.
- DRD and DWR both high: treated as a write, and ERR is set.
- Byte enables come from DLEN and DADDR[1:0]:
  - byte: lane = addr[1:0].
  - half: lanes {addr[1],0}+{0,1}.
  - word: all lanes.
- Misaligned access (half at odd address, word with addr[1:0]!=0) or non-one-hot DLEN:
  - write suppressed, ERR set; timing unchanged.
  - a read returns the aligned word normally.
- Array index is addr[MEM_AW+1:2]; upper bits are ignored, so addresses wrap modulo the array size.
- Instruction port:
  - IDATA <= mem[IADDR index] on every edge where HLT==0; IDATA holds while HLT==1.
  - IADDR[1:0] is ignored.
- Fetch and data write to the same word on the same edge: IDATA gets the old contents (read-before-write). A data read in DONE that follows a write to the same word sees the new contents.
- Reset asserted mid-access: the FSM aborts to IDLE immediately and the pending write is dropped. After release, the first request is handled as fresh.
- ERR clears only on RES.

Decomposition:
- Package darkram_pkg holds:
  - state enum (IDLE, WAIT, DONE);
  - DLEN encodings (DLEN_B, DLEN_H, DLEN_W);
  - NOP constant 32'h00000013;
  - byte-enable width constant 4.
- One sub-module, darkram_be_decode: combinational DLEN + addr[1:0] -> 4-bit byte-enable and misalign flag. It is reused by the bench scoreboard.

Test Plan:
- Reset release with INIT_FILE word0=32'h00100093, IADDR=0 -> IDATA=32'h00000013 during reset; IDATA=32'h00100093 one edge after release.
- WAIT_STATES=3; word read at 0x10 holding 32'hDEADBEEF -> HLT high exactly 4 cycles, DATAI=32'hDEADBEEF in the cycle HLT falls, IDATA frozen throughout.
- Byte write DATAO=32'hAAAAAAAA, DLEN=001, DADDR=0x22 over word 32'h11223344 -> word reads 32'h11AA3344, ERR=0.
- Half write DLEN=010 at DADDR=0x21 -> memory unchanged, ERR=1, HLT timing identical to an aligned access; ERR stays 1 until RES.
- Write 32'h12345678 to DADDR=0x4000 with MEM_AW=12 -> read at 0x0000 returns 32'h12345678 (wrap).
- WAIT_STATES=5; word write to 0x30 with RES pulsed during WAIT -> HLT=0 immediately, word 0x30 unchanged, next request completes with a 6-cycle stall.

Source files
------------

// File: rtl/darkram_pkg.sv
// Shared types and constants for the darkriscv memory-side responder.
// Imported by the responder, its byte-enable decoder and the bench.
package darkram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [2:0]  DLEN_B = 3'b001;
  localparam logic [2:0]  DLEN_H = 3'b010;
  localparam logic [2:0]  DLEN_W = 3'b100;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam int          BE_W   = 4;

endpackage

// File: rtl/darkram_be_decode.sv
// Turns access size and the low address bits into per-byte lane enables.
// Illegal sizes and misaligned accesses yield no enables and raise misalign.
module darkram_be_decode
  import darkram_pkg::*;
(
  input  logic [2:0]      dlen,
  input  logic [1:0]      addr_lo,
  output logic [BE_W-1:0] be,
  output logic            misalign
);

  always_comb begin
    be       = '0;
    misalign = 1'b0;
    case (dlen)
      DLEN_B: be = BE_W'(1) << addr_lo;
      DLEN_H: begin
        if (addr_lo[0]) misalign = 1'b1;
        else            be = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      DLEN_W: begin
        if (addr_lo != 2'b00) misalign = 1'b1;
        else                  be = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/darkram_responder.sv
// Unified instruction/data RAM for the darkriscv bus with a programmable
// number of wait states per data access, signalled to the core through HLT.
module darkram_responder
  import darkram_pkg::*;
#(
  parameter int    MEM_AW      = 12,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = "darksocv.mem"
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [31:0] IADDR,
  output logic [31:0] IDATA,
  input  logic        DAS,
  input  logic        DRD,
  input  logic        DWR,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAO,
  input  logic [2:0]  DLEN,
  output logic [31:0] DATAI,
  output logic        HLT,
  output logic        ERR
);

  localparam int DEPTH = 1 << MEM_AW;

  logic [31:0] mem [DEPTH];

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          cnt;
  logic [MEM_AW-1:0]   lat_idx;
  logic [31:0]         lat_data;
  logic [BE_W-1:0]     lat_be;
  logic                lat_wr_en;
  logic                lat_rd;

  logic                req;
  logic                hlt_c;
  logic                enter_done;
  logic                rd_now;
  logic [MEM_AW-1:0]   d_idx;
  logic [MEM_AW-1:0]   i_idx;
  logic [MEM_AW-1:0]   rd_idx;
  logic [BE_W-1:0]     be;
  logic                misalign;

  // Upper address bits fold away so the array wraps; IADDR[1:0] is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{IADDR[31:MEM_AW+2], IADDR[1:0], DADDR[31:MEM_AW+2]};

  assign req   = DAS & (DRD | DWR);
  assign d_idx = DADDR[MEM_AW+1:2];
  assign i_idx = IADDR[MEM_AW+1:2];

  darkram_be_decode u_be_decode (
    .dlen     (DLEN),
    .addr_lo  (DADDR[1:0]),
    .be       (be),
    .misalign (misalign)
  );

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = (WAIT_STATES > 0) ? WAIT : DONE;
      WAIT: begin
        if (!req)              state_nxt = IDLE;
        else if (cnt == 4'd1)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hlt_c = 1'b0;
    if (!RES) begin
      case (state)
        IDLE:    hlt_c = req;
        WAIT:    hlt_c = 1'b1;
        default: hlt_c = 1'b0;
      endcase
    end
  end

  assign HLT = hlt_c;

  // With zero wait states DONE is entered straight from IDLE, so the read
  // must use the live bus address rather than the latched one.
  assign enter_done = (state_nxt == DONE) && (state != DONE);
  assign rd_now     = (state == IDLE) ? (DRD & ~DWR) : lat_rd;
  assign rd_idx     = (state == IDLE) ? d_idx : lat_idx;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      cnt       <= '0;
      IDATA     <= NOP;
      DATAI     <= '0;
      ERR       <= 1'b0;
      lat_idx   <= '0;
      lat_data  <= '0;
      lat_be    <= '0;
      lat_wr_en <= 1'b0;
      lat_rd    <= 1'b0;
    end else begin
      if (!hlt_c) IDATA <= mem[i_idx];
      if (state == IDLE && req) begin
        lat_idx   <= d_idx;
        lat_data  <= DATAO;
        lat_be    <= be;
        lat_wr_en <= DWR & ~misalign;
        lat_rd    <= DRD & ~DWR;
        cnt       <= 4'(WAIT_STATES);
        if (misalign || (DRD && DWR)) ERR <= 1'b1;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_done && rd_now) DATAI <= mem[rd_idx];
    end
  end

  // Reset forces the FSM out of DONE, so a pending write never lands.
  always_ff @(posedge CLK) begin
    if (state == DONE && lat_wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_data[8*i +: 8];
      end
    end
  end

endmodule
